// File: rtl/mint_nested_if.sv
// Pipeline <-> interrupt controller bundle: raw irq/mask/enable inputs,
// take/eret handshakes from the pipeline, and the redirect/status outputs.
interface mint_nested_if #(
  parameter int NSRC = 4,
  parameter int AW   = 32
);
  logic [NSRC-1:0] in_irq;
  logic [NSRC-1:0] in_mask;
  logic            in_gie;
  logic            in_take;
  logic [AW-1:0]   in_EPC;
  logic            in_eret;
  logic            out_req;
  logic            out_force;
  logic [AW-1:0]   out_pc;
  logic [NSRC-1:0] out_IG;
  logic            out_NIE;
  logic [3:0]      out_depth;
  logic            out_err;

  // Pipeline side: drives the requests, observes the controller
  modport master (
    output in_irq, in_mask, in_gie, in_take, in_EPC, in_eret,
    input  out_req, out_force, out_pc, out_IG, out_NIE, out_depth, out_err
  );

  // Controller side
  modport slave (
    input  in_irq, in_mask, in_gie, in_take, in_EPC, in_eret,
    output out_req, out_force, out_pc, out_IG, out_NIE, out_depth, out_err
  );
endinterface

// File: rtl/mint_nested.sv
// Nested vectored interrupt controller. Edge-latched pending bits feed a
// fixed-priority arbiter (higher index wins) that only preempts a strictly
// lower in-service source. Accepted takes push {EPC, src} on a small stack;
// eret pops it. Both produce a one-cycle PC redirect strobe.
module mint_nested #(
  parameter int            NSRC      = 4,
  parameter int            DEPTH     = 4,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] VEC_BASE  = 32'h0000_0800,
  parameter int            VEC_SHIFT = 4
) (
  input logic           in_CLK,
  input logic           in_RST,
  mint_nested_if.slave  bus
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] irq_prev_r;
  logic [NSRC-1:0] pending_r;
  logic [AW-1:0]   epc_stk_r [DEPTH];
  logic [SW-1:0]   src_stk_r [DEPTH];
  logic [3:0]      depth_r;
  logic            force_r;
  logic [AW-1:0]   pc_r;
  logic [NSRC-1:0] ig_r;
  logic            err_r;

  logic [NSRC-1:0] edge_s;
  logic [NSRC-1:0] pending_nxt_s;
  logic            cand_vld_s;
  logic [SW-1:0]   cand_s;
  logic [SW-1:0]   top_src_s;
  logic [SW-1:0]   new_top_src_s;
  logic [AW-1:0]   pop_epc_s;
  logic [AW-1:0]   vec_s;
  logic            full_s;
  logic            empty_s;
  logic            req_s;
  logic            take_s;
  logic            pop_s;

  function automatic logic [NSRC-1:0] onehot(input logic [SW-1:0] src);
    onehot = {{(NSRC-1){1'b0}}, 1'b1} << src;
  endfunction

  // Highest-index pending and enabled source is the candidate
  always_comb begin
    cand_vld_s = 1'b0;
    cand_s     = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pending_r[i] && bus.in_mask[i]) begin
        cand_vld_s = 1'b1;
        cand_s     = SW'(i);
      end else begin
      end
    end
  end

  // Stack reads: top entry (in service / popped on eret) and the entry below it
  always_comb begin
    top_src_s     = '0;
    pop_epc_s     = '0;
    new_top_src_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (4'(k) + 4'd1 == depth_r) begin
        top_src_s = src_stk_r[k];
        pop_epc_s = epc_stk_r[k];
      end else begin
      end
      if (4'(k) + 4'd2 == depth_r) begin
        new_top_src_s = src_stk_r[k];
      end else begin
      end
    end
  end

  assign full_s  = (depth_r == 4'(DEPTH));
  assign empty_s = (depth_r == 4'd0);
  assign req_s   = bus.in_gie & ~full_s & cand_vld_s & (empty_s | (cand_s > top_src_s));
  // eret has priority over a simultaneous take; the pipeline retries the take
  assign pop_s   = bus.in_eret & ~empty_s;
  assign take_s  = bus.in_take & req_s & ~bus.in_eret;
  assign edge_s  = bus.in_irq & ~irq_prev_r;
  assign vec_s   = VEC_BASE + (AW'(cand_s) << VEC_SHIFT);
  // A fresh edge in the take cycle re-arms the bit being cleared
  assign pending_nxt_s = (pending_r & ~(take_s ? onehot(cand_s) : {NSRC{1'b0}})) | edge_s;

  // Edge detector, pending bits, nesting stack and depth
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      irq_prev_r <= '0;
      pending_r  <= '0;
      depth_r    <= 4'd0;
      for (int k = 0; k < DEPTH; k++) begin
        epc_stk_r[k] <= '0;
        src_stk_r[k] <= '0;
      end
    end else begin
      irq_prev_r <= bus.in_irq;
      pending_r  <= pending_nxt_s;
      if (pop_s) begin
        depth_r <= depth_r - 4'd1;
      end else if (take_s) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (4'(k) == depth_r) begin
            epc_stk_r[k] <= bus.in_EPC;
            src_stk_r[k] <= cand_s;
          end
        end
        depth_r <= depth_r + 4'd1;
      end
    end
  end

  // Registered redirect strobe/target, in-service one-hot and sticky error
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      force_r <= 1'b0;
      pc_r    <= '0;
      ig_r    <= '0;
      err_r   <= 1'b0;
    end else begin
      force_r <= pop_s | take_s;
      if (pop_s) begin
        pc_r <= pop_epc_s;
        ig_r <= (depth_r >= 4'd2) ? onehot(new_top_src_s) : {NSRC{1'b0}};
      end else if (take_s) begin
        pc_r <= vec_s;
        ig_r <= onehot(cand_s);
      end
      if (bus.in_eret && empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.out_req   = req_s;
  assign bus.out_force = force_r;
  assign bus.out_pc    = pc_r;
  assign bus.out_IG    = ig_r;
  assign bus.out_NIE   = bus.in_gie & ~full_s;
  assign bus.out_depth = depth_r;
  assign bus.out_err   = err_r;
endmodule

// File: tb/tb_mint_nested.sv
// Directed bench for mint_nested (NSRC=4, DEPTH=2): single take/eret,
// nesting, no-preempt priority, stack full, error/collision, async reset.
module tb_mint_nested;
  logic in_CLK;
  logic in_RST;
  int   n_checks;
  int   n_errors;

  mint_nested_if #(.NSRC(4), .AW(32)) bus ();

  mint_nested #(
    .NSRC(4), .DEPTH(2), .AW(32), .VEC_BASE(32'h0000_0800), .VEC_SHIFT(4)
  ) dut (
    .in_CLK (in_CLK),
    .in_RST (in_RST),
    .bus    (bus)
  );

  // 10 ns clock
  initial in_CLK = 1'b0;
  always #5 in_CLK = ~in_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge in_CLK);
    #1;
  endtask

  task automatic pulse_irq(input logic [3:0] lines);
    bus.in_irq = lines;
    cycle();
    bus.in_irq = 4'h0;
  endtask

  task automatic do_take(input logic [31:0] epc);
    bus.in_take = 1'b1;
    bus.in_EPC  = epc;
    cycle();
    bus.in_take = 1'b0;
  endtask

  task automatic do_eret();
    bus.in_eret = 1'b1;
    cycle();
    bus.in_eret = 1'b0;
  endtask

  task automatic expect_redirect(input string tag, input logic [31:0] pc,
                                 input logic [3:0] ig, input logic [3:0] depth);
    check({tag, "_force"}, 32'(bus.out_force), 32'd1);
    check({tag, "_pc"},    bus.out_pc,         pc);
    check({tag, "_ig"},    32'(bus.out_IG),    32'(ig));
    check({tag, "_depth"}, 32'(bus.out_depth), 32'(depth));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    in_RST      = 1'b0;
    bus.in_irq  = 4'h0;
    bus.in_mask = 4'hF;
    bus.in_gie  = 1'b1;
    bus.in_take = 1'b0;
    bus.in_EPC  = 32'h0;
    bus.in_eret = 1'b0;
    cycle();
    cycle();
    check("rst_force", 32'(bus.out_force), 32'd0);
    check("rst_pc",    bus.out_pc,         32'h0);
    check("rst_ig",    32'(bus.out_IG),    32'h0);
    check("rst_depth", 32'(bus.out_depth), 32'd0);
    check("rst_err",   32'(bus.out_err),   32'd0);
    check("rst_nie",   32'(bus.out_NIE),   32'd1);
    in_RST = 1'b1;
    cycle();
    check("idle_req", 32'(bus.out_req), 32'd0);

    // 1: single interrupt src1 and return
    pulse_irq(4'b0010);
    check("t1_req", 32'(bus.out_req), 32'd1);
    do_take(32'h100);
    expect_redirect("t1_take", 32'h810, 4'b0010, 4'd1);
    cycle();
    check("t1_pulse", 32'(bus.out_force), 32'd0);
    do_eret();
    expect_redirect("t1_eret", 32'h100, 4'b0000, 4'd0);

    // 2: src3 nests on top of src1
    pulse_irq(4'b0010);
    do_take(32'h100);
    pulse_irq(4'b1000);
    check("t2_req", 32'(bus.out_req), 32'd1);
    do_take(32'h204);
    expect_redirect("t2_take", 32'h830, 4'b1000, 4'd2);
    do_eret();
    expect_redirect("t2_eret1", 32'h204, 4'b0010, 4'd1);
    do_eret();
    expect_redirect("t2_eret2", 32'h100, 4'b0000, 4'd0);

    // 3: equal/lower priority never preempts; src2 then src0 afterwards
    pulse_irq(4'b0100);
    do_take(32'h300);
    pulse_irq(4'b0101);
    check("t3_nopreempt", 32'(bus.out_req), 32'd0);
    do_eret();
    expect_redirect("t3_eret", 32'h300, 4'b0000, 4'd0);
    check("t3_req2", 32'(bus.out_req), 32'd1);
    do_take(32'h400);
    expect_redirect("t3_take2", 32'h820, 4'b0100, 4'd1);
    do_eret();
    check("t3_req0", 32'(bus.out_req), 32'd1);
    do_take(32'h500);
    expect_redirect("t3_take0", 32'h800, 4'b0001, 4'd1);
    do_eret();
    check("t3_empty", 32'(bus.out_req), 32'd0);

    // masking hides the candidate but keeps it pending
    pulse_irq(4'b0010);
    bus.in_mask = 4'hD;
    #1;
    check("mask_req", 32'(bus.out_req), 32'd0);
    bus.in_mask = 4'hF;
    bus.in_gie  = 1'b0;
    #1;
    check("gie_req", 32'(bus.out_req), 32'd0);
    check("gie_nie", 32'(bus.out_NIE), 32'd0);
    bus.in_gie = 1'b1;
    #1;
    check("unmask_req", 32'(bus.out_req), 32'd1);

    // 5: eret on empty stack, then take+eret collision
    bus.in_take = 1'b0;
    do_eret();
    check("t5_noforce", 32'(bus.out_force), 32'd0);
    check("t5_err",     32'(bus.out_err),   32'd1);
    cycle();
    check("t5_err_sticky", 32'(bus.out_err), 32'd1);
    do_take(32'h600);
    expect_redirect("t5_take", 32'h810, 4'b0010, 4'd1);
    pulse_irq(4'b1000);
    check("t5_req", 32'(bus.out_req), 32'd1);
    bus.in_take = 1'b1;
    bus.in_eret = 1'b1;
    bus.in_EPC  = 32'h700;
    cycle();
    bus.in_take = 1'b0;
    bus.in_eret = 1'b0;
    expect_redirect("t5_coll", 32'h600, 4'b0000, 4'd0);
    check("t5_retry_req", 32'(bus.out_req), 32'd1);
    do_take(32'h700);
    expect_redirect("t5_retry", 32'h830, 4'b1000, 4'd1);
    do_eret();

    // 4: DEPTH=2 fill blocks requests until a slot frees
    pulse_irq(4'b0010);
    do_take(32'h110);
    pulse_irq(4'b0100);
    do_take(32'h120);
    expect_redirect("t4_fill", 32'h820, 4'b0100, 4'd2);
    check("t4_nie", 32'(bus.out_NIE), 32'd0);
    pulse_irq(4'b1000);
    check("t4_full_req", 32'(bus.out_req), 32'd0);
    do_eret();
    expect_redirect("t4_eret", 32'h120, 4'b0010, 4'd1);
    check("t4_req", 32'(bus.out_req), 32'd1);
    check("t4_nie1", 32'(bus.out_NIE), 32'd1);
    pulse_irq(4'b0001);
    do_take(32'h130);
    expect_redirect("t4_take", 32'h830, 4'b1000, 4'd2);

    // 6: asynchronous reset mid-handler, between clock edges
    #1;
    in_RST = 1'b0;
    #1;
    check("t6_force", 32'(bus.out_force), 32'd0);
    check("t6_depth", 32'(bus.out_depth), 32'd0);
    check("t6_ig",    32'(bus.out_IG),    32'h0);
    check("t6_err",   32'(bus.out_err),   32'd0);
    check("t6_req",   32'(bus.out_req),   32'd0);
    in_RST = 1'b1;
    cycle();
    check("t6_pending", 32'(bus.out_req),   32'd0);
    check("t6_post",    32'(bus.out_force), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
